// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic phase sequencer.
//   phase_t    : phase encoding seen on phase_state (ALLRED=00, GREEN=01,
//                AMBER=10).
//   MAX_DIR    : largest supported number of directions.
//   dir_onehot : one-hot lamp select for a direction index. It is MAX_DIR bits
//                wide; callers keep the low NUM_DIR bits.
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_AMBER  = 2'b10
    } phase_t;

    localparam int MAX_DIR = 16;

    function automatic logic [MAX_DIR-1:0] dir_onehot(input logic [3:0] dir);
        logic [MAX_DIR-1:0] v;
        v      = '0;
        v[dir] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/traffic_rr_pick.sv
// -----------------------------------------------------------------------------
// traffic_rr_pick
// Combinational round-robin picker. It returns the first set bit of mask,
// searching start+1, start+2, ... and wrapping, so that start itself is
// checked last.
//   mask  in  NUM_DIR  candidate directions (latched requests)
//   start in  DIR_W    direction served most recently
//   dir   out DIR_W    chosen direction (0 when valid=0)
//   valid out 1        at least one bit of mask is set
// -----------------------------------------------------------------------------
module traffic_rr_pick #(
    parameter  int NUM_DIR = 4,
    localparam int DIR_W   = $clog2(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] mask,
    input  logic [DIR_W-1:0]   start,
    output logic [DIR_W-1:0]   dir,
    output logic               valid
);

    // One extra bit holds start+i (up to 2*NUM_DIR-1) before the wrap.
    logic [DIR_W:0] sum;

    always_comb begin
        dir   = '0;
        valid = 1'b0;
        sum   = '0;
        for (int i = 1; i <= NUM_DIR; i++) begin
            sum = {1'b0, start} + (DIR_W+1)'(i);
            if (sum >= (DIR_W+1)'(NUM_DIR)) begin
                sum = sum - (DIR_W+1)'(NUM_DIR);
            end
            if (!valid && mask[sum[DIR_W-1:0]]) begin
                valid = 1'b1;
                dir   = sum[DIR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
// N-way intersection controller. It serves one direction at a time through
// GREEN -> AMBER -> ALL-RED in round-robin order. It supports demand-actuated
// skipping, rest-in-red, rest-in-green, an emergency preempt and a fixed-cycle
// mode (SKIP_EMPTY=0).
//   clk, rst     clock; asynchronous active-high reset
//   req          per-direction request pulses or levels
//   preempt      emergency preempt level; preempt_dir selects the direction
//                (a value >= NUM_DIR is ignored)
//   red/amber/green  registered lamp drives, one bit per direction
//   phase_dir    direction currently or last served
//   phase_state  FSM state: 00 ALLRED, 01 GREEN, 10 AMBER
//   pending      latched outstanding requests
// -----------------------------------------------------------------------------
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter  int NUM_DIR    = 4,
    parameter  int GREEN_CYC  = 25,
    parameter  int AMBER_CYC  = 5,
    parameter  int ALLRED_CYC = 2,
    parameter  int CNT_W      = 8,
    parameter  int SKIP_EMPTY = 1,
    localparam int DIR_W      = $clog2(NUM_DIR)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_DIR-1:0] req,
    input  logic               preempt,
    input  logic [DIR_W-1:0]   preempt_dir,
    output logic [NUM_DIR-1:0] red,
    output logic [NUM_DIR-1:0] amber,
    output logic [NUM_DIR-1:0] green,
    output logic [DIR_W-1:0]   phase_dir,
    output logic [1:0]         phase_state,
    output logic [NUM_DIR-1:0] pending
);

    phase_t               state, state_next;
    logic [DIR_W-1:0]     dir_next, dir_inc, pick_dir;
    logic [CNT_W-1:0]     timer, timer_next;
    logic [NUM_DIR-1:0]   pending_next, green_next, amber_next;
    logic [MAX_DIR-1:0]   sel_oh;
    logic                 pick_valid, other_pending, preempt_ok, enter_green;

    assign phase_state = state;

    // An out-of-range preempt direction is treated as no preempt.
    assign preempt_ok = preempt && (int'({1'b0, preempt_dir}) < NUM_DIR);
    assign dir_inc    = (phase_dir == DIR_W'(NUM_DIR-1)) ? '0 : phase_dir + 1'b1;

    traffic_rr_pick #(.NUM_DIR(NUM_DIR)) u_pick (
        .mask  (pending),
        .start (phase_dir),
        .dir   (pick_dir),
        .valid (pick_valid)
    );

    // The picker checks phase_dir last. If it returns phase_dir, no other
    // direction is waiting.
    assign other_pending = pick_valid && (pick_dir != phase_dir);

    always_comb begin
        state_next  = state;
        dir_next    = phase_dir;
        timer_next  = timer;
        case (state)
            PH_ALLRED: begin
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else if (preempt_ok) begin
                    state_next = PH_GREEN;
                    dir_next   = preempt_dir;
                end else if (SKIP_EMPTY == 0) begin
                    state_next = PH_GREEN;
                    dir_next   = dir_inc;
                end else if (pick_valid) begin
                    state_next = PH_GREEN;
                    dir_next   = pick_dir;
                end else begin
                    // Rest in red: the timer stays at 0, so the next cycle
                    // evaluates again.
                    timer_next = '0;
                end
            end
            PH_GREEN: begin
                if (preempt_ok && (preempt_dir != phase_dir)) begin
                    // A preempt for another direction cuts the minimum green.
                    state_next = PH_AMBER;
                end else if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else if (preempt_ok) begin
                    timer_next = '0;
                end else if ((SKIP_EMPTY != 0) && !other_pending) begin
                    timer_next = '0;
                end else begin
                    state_next = PH_AMBER;
                end
            end
            PH_AMBER: begin
                if (timer != '0) begin
                    timer_next = timer - 1'b1;
                end else begin
                    state_next = PH_ALLRED;
                end
            end
            default: begin
                state_next = PH_ALLRED;
            end
        endcase

        // Each state loads its full duration minus one when it is entered.
        if (state_next != state) begin
            case (state_next)
                PH_GREEN: timer_next = CNT_W'(GREEN_CYC - 1);
                PH_AMBER: timer_next = CNT_W'(AMBER_CYC - 1);
                default:  timer_next = CNT_W'(ALLRED_CYC - 1);
            endcase
        end
    end

    always_comb begin
        sel_oh       = dir_onehot(4'(dir_next));
        green_next   = (state_next == PH_GREEN) ? sel_oh[NUM_DIR-1:0] : '0;
        amber_next   = (state_next == PH_AMBER) ? sel_oh[NUM_DIR-1:0] : '0;
        enter_green  = (state_next == PH_GREEN) && (state != PH_GREEN);
        // On the GREEN entry edge, clearing the served direction takes
        // priority over a request arriving on the same edge.
        pending_next = (pending | req) & ~(enter_green ? sel_oh[NUM_DIR-1:0] : '0);
    end

    // State, served direction and lamps all update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= PH_ALLRED;
            phase_dir <= DIR_W'(NUM_DIR-1);
            red       <= '1;
            amber     <= '0;
            green     <= '0;
        end else begin
            state     <= state_next;
            phase_dir <= dir_next;
            red       <= ~(green_next | amber_next);
            amber     <= amber_next;
            green     <= green_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= CNT_W'(ALLRED_CYC - 1);
        end else begin
            timer <= timer_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
// Two sequencer instances share one clock and one reset:
//   dut0 uses SKIP_EMPTY=0 (fixed cycle), dut1 uses SKIP_EMPTY=1.
// Each cycle, the task that drives the stimulus pushes the expected packed
// vector {pending, phase_state, phase_dir, green, amber, red}. The vector is
// popped and compared #1 after the next rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_phase_sequencer;

    localparam int W = 20;
    localparam logic [1:0] S_ALLRED = 2'b00;
    localparam logic [1:0] S_GREEN  = 2'b01;
    localparam logic [1:0] S_AMBER  = 2'b10;

    logic       clk, rst;
    logic [3:0] req0, req1;
    logic       preempt0, preempt1;
    logic [1:0] pdir0, pdir1;
    logic [3:0] red0, amber0, green0, pending0;
    logic [3:0] red1, amber1, green1, pending1;
    logic [1:0] phase_dir0, phase_state0, phase_dir1, phase_state1;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    traffic_phase_sequencer #(.SKIP_EMPTY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .preempt(preempt0), .preempt_dir(pdir0),
        .red(red0), .amber(amber0), .green(green0), .phase_dir(phase_dir0),
        .phase_state(phase_state0), .pending(pending0)
    );

    traffic_phase_sequencer #(.SKIP_EMPTY(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .preempt(preempt1), .preempt_dir(pdir1),
        .red(red1), .amber(amber1), .green(green1), .phase_dir(phase_dir1),
        .phase_state(phase_state1), .pending(pending1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0 = '0; req1 = '0;
        preempt0 = 1'b0; preempt1 = 1'b0;
        pdir0 = '0; pdir1 = '0;
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    // ---------------- expected-value helpers ----------------
    function automatic logic [W-1:0] exp_vec(input logic [3:0] pend, input logic [1:0] st,
                                             input logic [1:0] dir);
        logic [3:0] oh, g, a;
        oh = 4'b0001 << dir;
        g  = (st == S_GREEN) ? oh : 4'b0000;
        a  = (st == S_AMBER) ? oh : 4'b0000;
        return {pend, st, dir, g, a, ~(g | a)};
    endfunction

    function automatic logic [W-1:0] pack0();
        return {pending0, phase_state0, phase_dir0, green0, amber0, red0};
    endfunction

    function automatic logic [W-1:0] pack1();
        return {pending1, phase_state1, phase_dir1, green1, amber1, red1};
    endfunction

    // Every direction shows exactly one lamp, and at most one direction is non-red.
    function automatic logic lamps_ok(input logic [3:0] r, input logic [3:0] a, input logic [3:0] g);
        return ((r | a | g) == 4'hF) && (((r & a) | (r & g) | (a & g)) == 4'h0)
               && ($countones(a | g) <= 1);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] got, exp;
        do_reset();
        for (int c = 1; c <= 10; c++) begin
            req1 = (c <= 2) ? 4'b0100 : 4'b1000;
            step();
        end
        exp_q.push_back(exp_vec(4'b1000, S_GREEN, 2'd2));
        exp_q.push_back(exp_vec(4'b0000, S_GREEN, 2'd0));
        got = pack1(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_pre_dut1 got=%b exp=%b", got, exp); end
        got = pack0(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_pre_dut0 got=%b exp=%b", got, exp); end
        // Assert the reset between clock edges. Being asynchronous, it must act without an edge.
        rst = 1'b1;
        exp_q.push_back(exp_vec(4'b0000, S_ALLRED, 2'd3));
        exp_q.push_back(exp_vec(4'b0000, S_ALLRED, 2'd3));
        #2;
        got = pack0(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_async_dut0 got=%b exp=%b", got, exp); end
        got = pack1(); exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL reset_async_dut1 got=%b exp=%b", got, exp); end
    endtask

    task automatic test_fixed_cycle();
        logic [W-1:0] got, exp;
        int k;
        do_reset();
        for (int c = 1; c <= 162; c++) begin
            // Requests and the preempt direction are noise while preempt=0 in fixed mode.
            req0  = 4'($urandom_range(0, 15));
            pdir0 = 2'($urandom_range(0, 3));
            if (c < 2) begin
                exp_q.push_back(exp_vec(4'b0000, S_ALLRED, 2'd3));
            end else begin
                k = c - 2;
                exp_q.push_back(exp_vec(4'b0000,
                    ((k % 32) < 25) ? S_GREEN : (((k % 32) < 30) ? S_AMBER : S_ALLRED),
                    2'((k / 32) % 4)));
            end
            step();
            got = pack0(); exp = exp_q.pop_front(); n_cmp++;
            if (got[15:0] !== exp[15:0]) begin
                n_err++; $display("FAIL fixed_cycle c=%0d got=%b exp=%b", c, got[15:0], exp[15:0]);
            end
            n_cmp++;
            if (!lamps_ok(red0, amber0, green0)) begin
                n_err++; $display("FAIL fixed_lamps c=%0d r=%b a=%b g=%b", c, red0, amber0, green0);
            end
        end
    endtask

    task automatic test_skip();
        logic [W-1:0] got, exp;
        do_reset();
        for (int c = 1; c <= 40; c++) begin
            req1 = (c == 6) ? 4'b0100 : 4'b0000;
            if (c < 6)       exp_q.push_back(exp_vec(4'b0000, S_ALLRED, 2'd3));
            else if (c == 6) exp_q.push_back(exp_vec(4'b0100, S_ALLRED, 2'd3));
            else             exp_q.push_back(exp_vec(4'b0000, S_GREEN, 2'd2));
            step();
            got = pack1(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL skip c=%0d got=%b exp=%b", c, got, exp); end
            n_cmp++;
            if (!lamps_ok(red1, amber1, green1)) begin
                n_err++; $display("FAIL skip_lamps c=%0d r=%b a=%b g=%b", c, red1, amber1, green1);
            end
        end
    endtask

    task automatic test_rest_in_green();
        logic [W-1:0] got, exp;
        int p;
        p = 45;
        do_reset();
        for (int c = 1; c <= 80; c++) begin
            req1 = (c == p) ? 4'b1010 : 4'b0010;
            if (c == 1)           exp_q.push_back(exp_vec(4'b0010, S_ALLRED, 2'd3));
            else if (c == 2)      exp_q.push_back(exp_vec(4'b0000, S_GREEN, 2'd1));
            else if (c < p)       exp_q.push_back(exp_vec(4'b0010, S_GREEN, 2'd1));
            else if (c == p)      exp_q.push_back(exp_vec(4'b1010, S_GREEN, 2'd1));
            else if (c <= p + 5)  exp_q.push_back(exp_vec(4'b1010, S_AMBER, 2'd1));
            else if (c <= p + 7)  exp_q.push_back(exp_vec(4'b1010, S_ALLRED, 2'd1));
            else if (c <= p + 32) exp_q.push_back(exp_vec(4'b0010, S_GREEN, 2'd3));
            else                  exp_q.push_back(exp_vec(4'b0010, S_AMBER, 2'd3));
            step();
            got = pack1(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL rest_green c=%0d got=%b exp=%b", c, got, exp); end
            n_cmp++;
            if (!lamps_ok(red1, amber1, green1)) begin
                n_err++; $display("FAIL rest_lamps c=%0d r=%b a=%b g=%b", c, red1, amber1, green1);
            end
        end
    endtask

    task automatic test_preempt();
        logic [W-1:0] got, exp;
        do_reset();
        for (int c = 1; c <= 60; c++) begin
            req1     = (c == 1) ? 4'b0001 : ((c == 30) ? 4'b1000 : 4'b0000);
            preempt1 = (c >= 11) && (c <= 50);
            pdir1    = 2'd2;
            if (c == 1)       exp_q.push_back(exp_vec(4'b0001, S_ALLRED, 2'd3));
            else if (c <= 10) exp_q.push_back(exp_vec(4'b0000, S_GREEN, 2'd0));
            else if (c <= 15) exp_q.push_back(exp_vec(4'b0000, S_AMBER, 2'd0));
            else if (c <= 17) exp_q.push_back(exp_vec(4'b0000, S_ALLRED, 2'd0));
            else if (c <= 50) exp_q.push_back(exp_vec((c >= 30) ? 4'b1000 : 4'b0000, S_GREEN, 2'd2));
            else if (c <= 55) exp_q.push_back(exp_vec(4'b1000, S_AMBER, 2'd2));
            else if (c <= 57) exp_q.push_back(exp_vec(4'b1000, S_ALLRED, 2'd2));
            else              exp_q.push_back(exp_vec(4'b0000, S_GREEN, 2'd3));
            step();
            got = pack1(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL preempt c=%0d got=%b exp=%b", c, got, exp); end
            n_cmp++;
            if (!lamps_ok(red1, amber1, green1)) begin
                n_err++; $display("FAIL preempt_lamps c=%0d r=%b a=%b g=%b", c, red1, amber1, green1);
            end
        end
        preempt1 = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] got, exp;
        do_reset();
        for (int c = 1; c <= 6; c++) begin
            req1 = (c == 1) ? 4'b0010 : ((c == 2) ? 4'b0110 : 4'b0000);
            if (c == 1) exp_q.push_back(exp_vec(4'b0010, S_ALLRED, 2'd3));
            else        exp_q.push_back(exp_vec(4'b0100, S_GREEN, 2'd1));
            step();
            got = pack1(); exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL simultaneous c=%0d got=%b exp=%b", c, got, exp); end
            n_cmp++;
            if (!lamps_ok(red1, amber1, green1)) begin
                n_err++; $display("FAIL simul_lamps c=%0d r=%b a=%b g=%b", c, red1, amber1, green1);
            end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_fixed_cycle();
        test_skip();
        test_rest_in_green();
        test_preempt();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
